// File: rtl/enc_8to3_arb_if.sv
// enc_8to3_arb_if: request/grant bus of the 8-to-3 encoder-arbiter.
// The slave modport is the arbiter side, the master modport is the requester/consumer side.
interface enc_8to3_arb_if;
  logic [7:0] req_in;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] pending;
  logic       busy;

  modport slave (
    input  req_in,
    input  out_ready,
    output out_valid,
    output out_idx,
    output pending,
    output busy
  );

  modport master (
    output req_in,
    output out_ready,
    input  out_valid,
    input  out_idx,
    input  pending,
    input  busy
  );
endinterface

// File: rtl/enc_8to3_arb.sv
// enc_8to3_arb: collects request pulses from eight sources into sticky
// pending bits and serialises them into 3-bit indices over valid/ready.
// Build option ENC_ROUND_ROBIN_EN: rotating scan starting after the last
// grant (starvation-free). Undefined: fixed priority, lowest index wins.
module enc_8to3_arb (
  input  logic          clk,
  input  logic          reset_n,
  enc_8to3_arb_if.slave bus
);

  logic [7:0] pend_q, pend_d;
  logic       out_valid_q, out_valid_d;
  logic [2:0] out_idx_q, out_idx_d;
  logic [7:0] scan;
  logic [2:0] sel_off;
  logic [2:0] sel;
  logic       sel_hit;
  logic       load;
  logic       grant;
  logic [7:0] clr_mask;

`ifdef ENC_ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;

  // Rotate pending so that scan[0] is the bit at the rotate pointer.
  always_comb begin
    scan = '0;
    for (int i = 0; i < 8; i++) begin
      scan[i] = pend_q[ptr_q + 3'(i)];
    end
  end

  // Undo the rotation to get the absolute index.
  always_comb sel = ptr_q + sel_off;

  // Pointer moves just past the granted index so it gets lowest priority next.
  always_comb ptr_d = grant ? sel + 3'd1 : ptr_q;

  // Rotate pointer register.
  always_ff @(posedge clk) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`else
  // Fixed priority: scan pending in natural order.
  always_comb scan = pend_q;

  // No rotation to undo.
  always_comb sel = sel_off;
`endif

  // Lowest set bit of the scan vector; descending loop lets the lowest win.
  always_comb begin
    sel_off = '0;
    for (int i = 7; i >= 0; i--) begin
      if (scan[i]) sel_off = 3'(i);
    end
  end

  // Load the output stage when it is empty or being accepted this cycle.
  always_comb begin
    sel_hit  = |pend_q;
    load     = !out_valid_q || bus.out_ready;
    grant    = load && sel_hit;
    clr_mask = grant ? (8'b1 << sel) : 8'b0;
  end

  // Next state; a fresh request on the bit being cleared keeps it set.
  always_comb begin
    pend_d      = (pend_q & ~clr_mask) | bus.req_in;
    out_valid_d = load ? sel_hit : out_valid_q;
    out_idx_d   = grant ? sel : out_idx_q;
  end

  // State registers; requests seen during reset are dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.pending   = pend_q;
  assign bus.busy      = (|pend_q) | out_valid_q;

endmodule

// File: doc/enc_8to3_arb.md
# enc_8to3_arb

Sequential 8-to-3 encoder and arbiter, the inverse of the register-file write-select decoder. It collects one-hot or multi-hot request pulses from eight sources, holds them as sticky pending bits, and emits one 3-bit index per accepted transfer over a valid/ready handshake. It sits upstream of the 3-to-8 decode path, for example to serialise competing writeback or forwarding requests into a single register-index stream.

## Interface
- No parameters. Width is fixed at 8 requesters and a 3-bit index.
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- req_in  input  8  request pulses; bit i set for one or more cycles requests service for index i
- out_ready  input  1  consumer accepts out_idx this cycle
- out_valid  output  1  out_idx holds a granted index
- out_idx  output  3  granted index (binary)
- pending  output  8  current sticky pending-request register
- busy  output  1  `(|pending) | out_valid`, combinational from registers

## Operation
- State: `pend[7:0]`, output stage `{out_valid, out_idx}`, rotate pointer `ptr[2:0]`.
- Reset (reset_n low at a clk edge):
  - `pend`, `out_valid`, `out_idx` and `ptr` all become 0; busy=0.
  - req_in sampled during reset is discarded.
  - Mid-operation reset drops all pending and in-flight grants with no completion.
- Load condition: `load = !out_valid | out_ready`.
- Selection (combinational from `pend`):
  - With round-robin, pick the first set bit scanning `ptr, ptr+1, …, 7, 0, …, ptr-1`.
  - `sel_hit=|pend`.
- On a clk edge with `load`:
  - `out_valid <= sel_hit`.
  - If `sel_hit`: `out_idx <= sel`, `ptr <= sel+1` (3-bit wrap, so 7 → 0), and bit `sel` is cleared from `pend`.
  - If `!sel_hit`: `out_idx` holds its old value.
- Pending update: `pend <= (pend & ~clr_mask) | req_in`.
  - A new request on the bit being cleared this cycle wins, so the bit stays set.
- With `load` false, the output stage and `ptr` hold. out_idx must not change while `out_valid & !out_ready`.
- Repeated requests on an already-pending bit coalesce into one grant.
- An index may appear in `out_idx` and be pending again at the same time, which yields two grants.

## Timing
- Latency: req_in at edge N sets pend at edge N; out_valid=1 with that index after edge N+1 (2-cycle request-to-valid), provided the output stage is free or being accepted.
- Throughput: one grant per cycle while out_ready=1 and pend≠0.
- Handshake: a transfer occurs at an edge where `out_valid & out_ready`. out_ready while out_valid=0 has no effect beyond permitting a load.
- Empty: with pend=0 and a transfer accepted, out_valid drops to 0 at the next edge.
- Full: all eight bits pending is legal. Nothing is lost; extra pulses coalesce.

## Configuration
- `ENC_ROUND_ROBIN_EN` defined: rotating scan from `ptr` as described above. This gives starvation-free service; any pending bit is granted within 8 transfers.
- Not defined: fixed priority, lowest index wins. `ptr` is removed, or held at 0 and ignored. A continuously requested low index can starve higher ones.

## Test plan
- Reset, then pulse `req_in=8'h20` for 1 cycle with out_ready=1 → out_valid=1, out_idx=5 two edges after the pulse, then out_valid=0 on the next edge; pending=0; busy=0.
- Pulse `req_in=8'hFF` once with out_ready=1 (round-robin) → out_idx 0,1,2,…,7 on consecutive cycles, then out_valid=0.
- Backpressure: req_in 0x0A with out_ready=0 → out_valid=1, out_idx=1 held stable for 5 cycles, pending=0x08. Raise out_ready → idx 3 follows next cycle.
- Fairness: hold req_in=0x41 continuously with out_ready=1.
  - With `ENC_ROUND_ROBIN_EN`: grants alternate 0,6,0,6.
  - Without it: grants are 0 every cycle and idx 6 never appears.
- Simultaneous set and clear: while idx 2 is being selected, pulse req_in bit 2 → 2 is granted, pending[2] stays 1, and 2 is granted again later.
- Reset mid-operation: pend=0xF0 and out_valid=1, assert reset_n=0 for one edge with req_in=0xFF → all outputs 0 and no grant afterwards.
